// File: rtl/bicubic_pkg.sv
// bicubic_pkg: shared lane-width defaults, shift amount and frame counter type
package bicubic_pkg;
  localparam int DEF_CORES       = 2;
  localparam int DEF_IN_W        = 9;
  localparam int DEF_LSHIFT      = 8;
  localparam int DEF_OUT_W       = 48;
  localparam int DEF_FRAME_BEATS = 1024;
  localparam int CNT_W           = 16;
  typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/bicubic_nx_simd_pack_if.sv
// bicubic_nx_simd_pack_if: pixel-in / packed-operand-out stream bus
interface bicubic_nx_simd_pack_if
  import bicubic_pkg::*;
#(
  parameter int PARALLEL_CORE = DEF_CORES,
  parameter int INPUT_WIDTH   = DEF_IN_W,
  parameter int OUTPUT_WIDTH  = DEF_OUT_W
);
  logic [INPUT_WIDTH*PARALLEL_CORE-1:0]  pin_ch0, pin_ch1;
  logic                                  in_valid, in_ready;
  logic [OUTPUT_WIDTH*PARALLEL_CORE-1:0] pout_ch0, pout_ch1;
  logic                                  out_valid, out_ready, out_last;
  modport slave (
    input  pin_ch0, pin_ch1, in_valid, out_ready,
    output in_ready, pout_ch0, pout_ch1, out_valid, out_last
  );
  modport master (
    output pin_ch0, pin_ch1, in_valid, out_ready,
    input  in_ready, pout_ch0, pout_ch1, out_valid, out_last
  );
endinterface

// File: rtl/simd2x_pack.sv
// simd2x_pack: one core's two-stage sign-extend then left-shift pack for ch0/ch1
module simd2x_pack
  import bicubic_pkg::*;
#(
  parameter int INPUT_WIDTH  = DEF_IN_W,
  parameter int LSHIFT_RANGE = DEF_LSHIFT,
  parameter int OUTPUT_WIDTH = DEF_OUT_W
) (
  input  logic                           clk,
  input  logic                           areset,
  input  logic                           i_ld1,
  input  logic                           i_ld2,
  input  logic signed [INPUT_WIDTH-1:0]  i_ch0,
  input  logic signed [INPUT_WIDTH-1:0]  i_ch1,
  output logic [OUTPUT_WIDTH-1:0]        o_ch0,
  output logic [OUTPUT_WIDTH-1:0]        o_ch1
);
  localparam int EW = OUTPUT_WIDTH - LSHIFT_RANGE;
  logic [EW-1:0]           r_s1_ch0, r_s1_ch1;
  logic [OUTPUT_WIDTH-1:0] r_s2_ch0, r_s2_ch1;
  assign o_ch0 = r_s2_ch0;
  assign o_ch1 = r_s2_ch1;
  // S1: hold the lanes sign-extended to the pre-shift width
  always_ff @(posedge clk or posedge areset)
    if (areset) begin
      r_s1_ch0 <= '0;
      r_s1_ch1 <= '0;
    end else if (i_ld1) begin
      r_s1_ch0 <= EW'(i_ch0);
      r_s1_ch1 <= EW'(i_ch1);
    end
  // S2: append the zero fraction bits, giving an exact left shift
  always_ff @(posedge clk or posedge areset)
    if (areset) begin
      r_s2_ch0 <= '0;
      r_s2_ch1 <= '0;
    end else if (i_ld2) begin
      r_s2_ch0 <= {r_s1_ch0, {LSHIFT_RANGE{1'b0}}};
      r_s2_ch1 <= {r_s1_ch1, {LSHIFT_RANGE{1'b0}}};
    end
endmodule

// File: rtl/bicubic_nx_simd_pack.sv
// bicubic_nx_simd_pack: skid-buffered two-stage SIMD pixel-to-DSP-operand packer
module bicubic_nx_simd_pack
  import bicubic_pkg::*;
#(
  parameter int PARALLEL_CORE = DEF_CORES,
  parameter int INPUT_WIDTH   = DEF_IN_W,
  parameter int LSHIFT_RANGE  = DEF_LSHIFT,
  parameter int OUTPUT_WIDTH  = DEF_OUT_W,
  parameter int FRAME_BEATS   = DEF_FRAME_BEATS
) (
  input logic                   clk,
  input logic                   areset,
  input logic                   clken,
  input logic                   dsp_reset,
  bicubic_nx_simd_pack_if.slave bus
);
  localparam int   BW   = INPUT_WIDTH * PARALLEL_CORE;
  localparam int   OW   = OUTPUT_WIDTH * PARALLEL_CORE;
  localparam cnt_t LAST = cnt_t'(FRAME_BEATS - 1);
  if (OUTPUT_WIDTH < INPUT_WIDTH + LSHIFT_RANGE) begin : g_width_check
    $error("OUTPUT_WIDTH cannot hold INPUT_WIDTH+LSHIFT_RANGE exactly");
  end
  logic          r_rdy, r_skid_v, r_s1_v, r_s2_v;
  logic [BW-1:0] r_skid0, r_skid1;
  cnt_t          r_cnt;
  logic          w_in_xfer, w_out_xfer, w_s1_adv, w_s2_adv, w_ld1, w_ld2, w_hold;
  logic [BW-1:0] w_src0, w_src1;
  logic [OW-1:0] w_pout0, w_pout1;
  assign bus.in_ready  = r_rdy & clken;
  assign bus.out_valid = r_s2_v & clken;
  assign bus.out_last  = r_s2_v & (r_cnt == LAST);
  assign bus.pout_ch0  = w_pout0;
  assign bus.pout_ch1  = w_pout1;
  assign w_in_xfer     = bus.in_valid & bus.in_ready;
  assign w_out_xfer    = bus.out_valid & bus.out_ready;
  assign w_s2_adv      = !r_s2_v | w_out_xfer;
  assign w_s1_adv      = !r_s1_v | w_s2_adv;
  assign w_hold        = (r_skid_v | w_in_xfer) & !w_s1_adv;
  assign w_ld1         = clken & w_s1_adv & (r_skid_v | w_in_xfer);
  assign w_ld2         = clken & w_s2_adv & r_s1_v;
  assign w_src0        = r_skid_v ? r_skid0 : bus.pin_ch0;
  assign w_src1        = r_skid_v ? r_skid1 : bus.pin_ch1;
  // control: skid/stage valids, registered ready and frame beat counter; flush beats any transfer
  always_ff @(posedge clk or posedge areset)
    if (areset) begin
      r_rdy    <= 1'b0;
      r_skid_v <= 1'b0;
      r_s1_v   <= 1'b0;
      r_s2_v   <= 1'b0;
      r_cnt    <= '0;
    end else if (clken && dsp_reset) begin
      r_rdy    <= 1'b1;
      r_skid_v <= 1'b0;
      r_s1_v   <= 1'b0;
      r_s2_v   <= 1'b0;
      r_cnt    <= '0;
    end else if (clken) begin
      r_rdy    <= !w_hold;
      r_skid_v <= w_hold;
      if (w_s1_adv) r_s1_v <= r_skid_v | w_in_xfer;
      if (w_s2_adv) r_s2_v <= r_s1_v;
      if (w_out_xfer) r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
  // skid data: park an accepted beat when S1 cannot take it this cycle
  always_ff @(posedge clk)
    if (w_in_xfer && !w_s1_adv) begin
      r_skid0 <= bus.pin_ch0;
      r_skid1 <= bus.pin_ch1;
    end
  for (genvar g = 0; g < PARALLEL_CORE; g++) begin : g_core
    simd2x_pack #(
      .INPUT_WIDTH (INPUT_WIDTH),
      .LSHIFT_RANGE(LSHIFT_RANGE),
      .OUTPUT_WIDTH(OUTPUT_WIDTH)
    ) u_core (
      .clk   (clk),
      .areset(areset),
      .i_ld1 (w_ld1),
      .i_ld2 (w_ld2),
      .i_ch0 (w_src0[g*INPUT_WIDTH +: INPUT_WIDTH]),
      .i_ch1 (w_src1[g*INPUT_WIDTH +: INPUT_WIDTH]),
      .o_ch0 (w_pout0[g*OUTPUT_WIDTH +: OUTPUT_WIDTH]),
      .o_ch1 (w_pout1[g*OUTPUT_WIDTH +: OUTPUT_WIDTH])
    );
  end
endmodule

// File: tb/tb_bicubic_nx_simd_pack.sv
// tb_bicubic_nx_simd_pack: directed checks of packing, handshake, framing, flush and clock enable
module tb_bicubic_nx_simd_pack;
  logic clk = 1'b0, areset = 1'b0, clken = 1'b1, dsp_reset = 1'b0;
  bicubic_nx_simd_pack_if #(.PARALLEL_CORE(2), .INPUT_WIDTH(9), .OUTPUT_WIDTH(48)) bus ();
  bicubic_nx_simd_pack #(.FRAME_BEATS(4)) dut (
    .clk(clk), .areset(areset), .clken(clken), .dsp_reset(dsp_reset), .bus(bus)
  );
  always #5 clk = ~clk;
  typedef struct { logic [95:0] c0, c1; } beat_t;
  beat_t q[$];
  beat_t e;
  int n_chk = 0, n_err = 0, cyc = 0, mcnt = 0, kb = 0, got = 0;
  int n_acc, n_out, n_last, t_acc, t_out, t_end;
  logic [8:0] vals [16] = '{9'h100, 9'h0FF, 9'h000, 9'h1FF, 9'h001, 9'h1FE, 9'h064, 9'h19C,
                            9'h025, 9'h1DB, 9'h080, 9'h17F, 9'h0C8, 9'h138, 9'h005, 9'h04D};
  task automatic chk(input string tag, input logic [95:0] got_v, input logic [95:0] exp_v);
    n_chk++;
    if (got_v !== exp_v) begin
      n_err++;
      $display("FAIL %s got %h expected %h", tag, got_v, exp_v);
    end
  endtask
  function automatic logic [47:0] sh(input logic [8:0] v);
    return 48'($signed(v)) * 48'd256;
  endfunction
  function automatic logic [95:0] exp_bus(input logic [17:0] p);
    return {sh(p[17:9]), sh(p[8:0])};
  endfunction
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic set_beat(input int k);
    bus.pin_ch0 = {vals[(k+1)%16], vals[k%16]};
    bus.pin_ch1 = {vals[(k+3)%16], vals[(k+2)%16]};
  endtask
  task automatic win();
    n_acc = 0; n_out = 0; n_last = 0; t_acc = -1; t_out = -1; t_end = -1;
  endtask
  task automatic stream(input int nb, input int maxc, output int acc);
    acc = 0;
    bus.in_valid = 1'b1;
    for (int c = 0; c < maxc && acc < nb; c++) begin
      set_beat(kb);
      if (bus.in_ready) begin acc++; kb++; end
      tick(1);
    end
    bus.in_valid = 1'b0;
  endtask
  task automatic drain();
    for (int c = 0; c < 20 && q.size() > 0; c++) tick(1);
    chk("drain", 96'(q.size()), 96'd0);
  endtask
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (areset || (clken && dsp_reset)) begin
      q.delete();
      mcnt = 0;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) chk("out_spurious", 96'd1, 96'd0);
        else begin
          e = q.pop_front();
          chk("pout_ch0", bus.pout_ch0, e.c0);
          chk("pout_ch1", bus.pout_ch1, e.c1);
        end
        chk("out_last", 96'(bus.out_last), 96'(mcnt == 3));
        if (bus.out_last) n_last++;
        mcnt = (mcnt + 1) % 4;
        if (t_out < 0) t_out = cyc;
        t_end = cyc;
        n_out++;
      end
      if (bus.in_valid && bus.in_ready) begin
        e.c0 = exp_bus(bus.pin_ch0);
        e.c1 = exp_bus(bus.pin_ch1);
        q.push_back(e);
        if (t_acc < 0) t_acc = cyc;
        n_acc++;
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    bus.pin_ch0 = '0; bus.pin_ch1 = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    win();
    #2 areset = 1'b1;
    #2;
    chk("rst_out_valid", 96'(bus.out_valid), 96'd0);
    chk("rst_out_last", 96'(bus.out_last), 96'd0);
    chk("rst_pout_ch0", bus.pout_ch0, 96'd0);
    chk("rst_pout_ch1", bus.pout_ch1, 96'd0);
    chk("rst_in_ready", 96'(bus.in_ready), 96'd0);
    tick(1);
    areset = 1'b0;
    #1 chk("rdy_before_edge", 96'(bus.in_ready), 96'd0);
    tick(1);
    chk("rdy_after_edge", 96'(bus.in_ready), 96'd1);
    // lane values -256,+255 on ch0 and 0,-1 on ch1, held under backpressure
    bus.pin_ch0 = {9'h0FF, 9'h100};
    bus.pin_ch1 = {9'h1FF, 9'h000};
    bus.in_valid = 1'b1;
    tick(1);
    bus.in_valid = 1'b0;
    tick(2);
    chk("vec_valid", 96'(bus.out_valid), 96'd1);
    chk("vec_m256", 96'(bus.pout_ch0[47:0]), 96'h0000_0000_0000_FFFF_FFFF_0000);
    chk("vec_p255", 96'(bus.pout_ch0[95:48]), 96'h0000_0000_0000_0000_0000_FF00);
    chk("vec_zero", 96'(bus.pout_ch1[47:0]), 96'd0);
    chk("vec_m1", 96'(bus.pout_ch1[95:48]), 96'h0000_0000_0000_FFFF_FFFF_FF00);
    tick(3);
    chk("vec_stable", bus.pout_ch0, 96'h0000_0000_FF00_FFFF_FFFF_0000);
    chk("vec_hold_rdy", 96'(bus.in_ready), 96'd1);
    bus.out_ready = 1'b1;
    tick(1);
    chk("vec_consumed", 96'(bus.out_valid), 96'd0);
    // flush while a beat is leaving and another is arriving
    stream(1, 4, got);
    tick(1);
    set_beat(kb);
    bus.in_valid = 1'b1;
    dsp_reset = 1'b1;
    chk("flush_pre_valid", 96'(bus.out_valid), 96'd1);
    tick(1);
    dsp_reset = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_valid", 96'(bus.out_valid), 96'd0);
    chk("flush_ready", 96'(bus.in_ready), 96'd1);
    tick(3);
    chk("flush_discard", 96'(bus.out_valid), 96'd0);
    // 9-beat stream from a cleared counter: latency, back-to-back, frame ends
    win();
    stream(9, 20, got);
    chk("str_accepts", 96'(got), 96'd9);
    drain();
    chk("str_latency", 96'(t_out - t_acc), 96'd2);
    chk("str_span", 96'(t_end - t_out), 96'd8);
    chk("str_outs", 96'(n_out), 96'd9);
    chk("str_lasts", 96'(n_last), 96'd2);
    // 6 cycles of backpressure from an empty pipe
    win();
    bus.out_ready = 1'b0;
    stream(8, 6, got);
    chk("bp_accepts", 96'(got), 96'd3);
    chk("bp_ready_low", 96'(bus.in_ready), 96'd0);
    chk("bp_valid_held", 96'(bus.out_valid), 96'd1);
    bus.out_ready = 1'b1;
    stream(5, 20, got);
    chk("bp_more", 96'(got), 96'd5);
    drain();
    chk("bp_outs", 96'(n_out), 96'd8);
    chk("bp_io", 96'(n_acc), 96'd8);
    // clock enable toggling every cycle
    win();
    got = 0;
    for (int c = 0; c < 16; c++) begin
      clken = (c % 2 == 0);
      bus.in_valid = (got < 4);
      set_beat(kb);
      #1;
      if (!clken) begin
        chk("ce_ready_low", 96'(bus.in_ready), 96'd0);
        chk("ce_valid_low", 96'(bus.out_valid), 96'd0);
      end else if (bus.in_valid && bus.in_ready) begin
        got++;
        kb++;
      end
      tick(1);
    end
    clken = 1'b1;
    bus.in_valid = 1'b0;
    chk("ce_accepts", 96'(got), 96'd4);
    chk("ce_outs", 96'(n_out), 96'd4);
    chk("ce_span", 96'(t_end - t_out), 96'd6);
    chk("ce_latency", 96'(t_out - t_acc), 96'd4);
    chk("ce_queue", 96'(q.size()), 96'd0);
    // asynchronous reset with beats in flight
    win();
    bus.in_valid = 1'b1;
    set_beat(kb);
    tick(1);
    kb++;
    set_beat(kb);
    tick(1);
    kb++;
    chk("ar_pre_valid", 96'(bus.out_valid), 96'd1);
    areset = 1'b1;
    #1;
    chk("ar_valid", 96'(bus.out_valid), 96'd0);
    chk("ar_ready", 96'(bus.in_ready), 96'd0);
    chk("ar_pout", bus.pout_ch0, 96'd0);
    chk("ar_last", 96'(bus.out_last), 96'd0);
    bus.in_valid = 1'b0;
    tick(1);
    areset = 1'b0;
    tick(1);
    chk("ar_ready_back", 96'(bus.in_ready), 96'd1);
    tick(3);
    chk("ar_no_leak", 96'(bus.out_valid), 96'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/bicubic_nx_simd_pack.md
BICUBIC_NX_SIMD_PACK -- requirements
Module: bicubic_nx_simd_pack

Interface
REQ-001 The block SHALL have parameter PARALLEL_CORE, default 2, number of parallel SIMD 2x pack cores.
REQ-002 The block SHALL have parameter INPUT_WIDTH, default 9, signed pixel lane width.
REQ-003 The block SHALL have parameter LSHIFT_RANGE, default 8, left-shift bits (inverse of the rounding right shift).
REQ-004 The block SHALL have parameter OUTPUT_WIDTH, default 48, signed DSP operand lane width.
REQ-005 The block SHALL have parameter FRAME_BEATS, default 1024, output beats per frame (range 1..65536).
REQ-006 The block SHALL have port clk, input, 1, the single clock.
REQ-007 The block SHALL have port areset, input, 1, asynchronous active-high reset.
REQ-008 The block SHALL have port clken, input, 1, clock enable.
REQ-009 The block SHALL have port dsp_reset, input, 1, synchronous pipeline flush.
REQ-010 The block SHALL have ports pin_ch0 and pin_ch1, input, INPUT_WIDTH*PARALLEL_CORE each, signed pixel lanes (core i at bits [(i+1)*INPUT_WIDTH-1 : i*INPUT_WIDTH]).
REQ-011 The block SHALL have port in_valid, input, 1, and port in_ready, output, 1, the input handshake.
REQ-012 The block SHALL have ports pout_ch0 and pout_ch1, output, OUTPUT_WIDTH*PARALLEL_CORE each, signed packed DSP operands (same lane ordering).
REQ-013 The block SHALL have port out_valid, output, 1, port out_ready, input, 1, and port out_last, output, 1, last beat of frame.

Function
REQ-014 Each output lane SHALL equal sign-extend(input lane) shifted left by LSHIFT_RANGE, with the low LSHIFT_RANGE bits zero and the result exact.
REQ-015 Elaboration SHALL fail if OUTPUT_WIDTH < INPUT_WIDTH+LSHIFT_RANGE.
REQ-016 A beat SHALL transfer on either side only on a cycle with valid, ready and clken all high.
REQ-017 When clken=0, all registers SHALL hold and in_ready and out_valid SHALL read 0.
REQ-018 A one-entry input skid register SHALL drive in_ready from a flop: in_ready=1 exactly when the skid is empty.
REQ-019 The datapath SHALL have two stages: S1 registers the sign-extended lanes; S2 shifts and packs and drives pout_*/out_valid.
REQ-020 A stage SHALL advance when its downstream is empty or being consumed in the same cycle.
REQ-021 With in_valid=out_ready=clken=1 continuously, the block SHALL accept one beat per cycle, and each beat SHALL appear with out_valid exactly 2 cycles after acceptance.
REQ-022 Under out_ready=0, S2 SHALL hold, then S1 SHALL hold, then the skid SHALL fill and in_ready SHALL fall; no beat may be lost or duplicated, and order is preserved.
REQ-023 pout_* SHALL remain stable while out_valid=1 and out_ready=0.
REQ-024 A 16-bit beat counter SHALL increment on each output transfer; out_last=1 when count = FRAME_BEATS-1, and the counter SHALL wrap to 0 on that transfer.
REQ-025 dsp_reset=1 (clken-qualified) SHALL clear skid, S1 and S2 valids and the beat counter next edge; in_ready SHALL then return to 1, and data registers need not clear.
REQ-026 If dsp_reset coincides with an input or output transfer, the flush SHALL win: the accepted beat is discarded and the counter SHALL be 0.

Reset
REQ-027 On areset=1, asynchronously: out_valid=0, out_last=0, pout_*=0, beat counter=0, all stage valids=0, and in_ready=0.
REQ-028 in_ready SHALL rise on the first clken-high edge after areset deasserts.
REQ-029 areset asserted mid-transfer SHALL discard all in-flight beats.

Structure
REQ-030 Lane width defaults, LSHIFT_RANGE and the FRAME_BEATS counter width SHALL live in shared package bicubic_pkg.
REQ-031 Per-core datapath (S1/S2 registers for ch0/ch1, sign-extend, shift) SHALL be sub-module simd2x_pack, instantiated PARALLEL_CORE times by generate, with handshake and counter control in the top module.

Verification
REQ-032 Lane values -256, +255, 0, -1 with defaults -> outputs 0xFFFFFFFF0000, 0x00000000FF00, 0x0, 0xFFFFFFFFFF00.
REQ-033 Stream 8 beats with out_ready=1 -> out_valid first at 2 cycles after the first accept, 8 consecutive beats in order.
REQ-034 out_ready=0 for 6 cycles during a stream -> in_ready falls after 3 accepted beats, with no loss or duplication after release.
REQ-035 FRAME_BEATS=4, stream 9 beats -> out_last on beats 4 and 8 only.
REQ-036 dsp_reset on a cycle with out_valid=1 and out_ready=1 -> next cycle out_valid=0, counter=0, in_ready=1.
REQ-037 clken toggling 1/0 every cycle -> identical output sequence at half rate, with in_ready/out_valid=0 on clken-low cycles.
